// File: rtl/alu_muldiv_seq_if.sv
// Operand/result bus between the sequencer and alu_muldiv_seq.
// master: drives clk_en, i_start, i_abort, i_op, i_latch_flags, i_a, i_t;
//         observes o_busy, o_done, o_data, o_zero, o_carry, o_odd.
// slave : the multiply/divide unit itself.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 8
);
  logic             clk_en;
  logic             i_start;
  logic             i_abort;
  logic [1:0]       i_op;
  logic             i_latch_flags;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_t;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_data;
  logic             o_zero;
  logic             o_carry;
  logic             o_odd;

  modport master (
    output clk_en, i_start, i_abort, i_op, i_latch_flags, i_a, i_t,
    input  o_busy, o_done, o_data, o_zero, o_carry, o_odd
  );

  modport slave (
    input  clk_en, i_start, i_abort, i_op, i_latch_flags, i_a, i_t,
    output o_busy, o_done, o_data, o_zero, o_carry, o_odd
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply / restoring divide, one bit per enabled clock.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_muldiv_seq_if.slave: clk_en, start/abort handshake, op select
//          (00 MUL, 01 MULH, 10 DIV, 11 MOD), operands i_a/i_t, busy/done,
//          registered result o_data and latched zero/carry/odd flags.
//
// state   | meaning
// IDLE    | waiting for i_start
// RUN     | iterating, WIDTH enabled cycles
// DONE    | result valid, o_done high for one enabled cycle
module alu_muldiv_seq #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
  input logic             clk,
  input logic             rst,
  alu_muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic                 accept, finish;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q, t_q;
  logic                 latch_q;
  logic [2*WIDTH-1:0]   prod_q, prod_nx;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     quot_q, quot_nx;
  logic [WIDTH-1:0]     rem_q, rem_nx;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_borrow;
  logic [WIDTH-1:0]     result;
  logic                 carry_res;
  logic [WIDTH-1:0]     data_q;
  logic                 zero_q, carry_q, odd_q;
  logic                 last_iter;

  assign last_iter = (cnt_q == CNT_WIDTH'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    if (bus.clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            state_d = ST_RUN;
            accept  = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.i_abort) state_d = ST_IDLE;
          else if (last_iter) begin
            state_d = ST_DONE;
            finish  = 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.i_abort) state_d = ST_IDLE;
          else if (bus.i_start) begin
            state_d = ST_RUN;
            accept  = 1'b1;
          end else state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shift-add step: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};
  assign prod_nx = {mul_sum, prod_q[WIDTH-1:1]};

  // Restoring step on the WIDTH+1-bit shifted remainder. When no borrow the
  // difference is below the divisor, so WIDTH bits hold it exactly. A zero
  // divisor never borrows, giving all-ones quotient and remainder = dividend.
  assign rem_sh     = {rem_q, quot_q[WIDTH-1]};
  assign div_borrow = (rem_sh < {1'b0, t_q});
  assign div_diff   = rem_sh[WIDTH-1:0] - t_q;
  assign rem_nx     = div_borrow ? rem_sh[WIDTH-1:0] : div_diff;
  assign quot_nx    = {quot_q[WIDTH-2:0], ~div_borrow};

  always_comb begin
    result = prod_nx[WIDTH-1:0];
    case (op_q)
      2'b00: result = prod_nx[WIDTH-1:0];
      2'b01: result = prod_nx[2*WIDTH-1:WIDTH];
      2'b10: result = quot_nx;
      2'b11: result = rem_nx;
      default: result = prod_nx[WIDTH-1:0];
    endcase
    carry_res = op_q[1] ? (t_q == {WIDTH{1'b0}}) : (|prod_nx[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      t_q     <= '0;
      latch_q <= 1'b0;
      prod_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      odd_q   <= 1'b0;
    end else if (bus.clk_en) begin
      if (accept) begin
        cnt_q   <= '0;
        op_q    <= bus.i_op;
        a_q     <= bus.i_a;
        t_q     <= bus.i_t;
        latch_q <= bus.i_latch_flags;
        prod_q  <= {{WIDTH{1'b0}}, bus.i_t};
        quot_q  <= bus.i_a;
        rem_q   <= '0;
      end else if (state_q == ST_RUN && !bus.i_abort) begin
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
        prod_q <= prod_nx;
        quot_q <= quot_nx;
        rem_q  <= rem_nx;
        if (finish) begin
          data_q <= result;
          if (latch_q) begin
            zero_q  <= (result == {WIDTH{1'b0}});
            carry_q <= carry_res;
            odd_q   <= result[0];
          end
        end
      end
    end
  end

  assign bus.o_busy  = (state_q == ST_RUN);
  assign bus.o_done  = (state_q == ST_DONE);
  assign bus.o_data  = data_q;
  assign bus.o_zero  = zero_q;
  assign bus.o_carry = carry_q;
  assign bus.o_odd   = odd_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(W)) ifc();
  alu_muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         carry;
    logic         odd;
    int           done_edge;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int en_edges = 0;
  bit last_en = 1'b0;

  // reference architectural state
  logic [W-1:0] m_data;
  logic m_zero, m_carry, m_odd;
  logic [W-1:0] sv_data;
  logic sv_zero, sv_carry, sv_odd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) begin
    last_en = ifc.clk_en;
    if (ifc.clk_en) en_edges++;
  end

  // monitor: one completion per enabled edge that leaves o_done high
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ifc.o_done && last_en) begin
      if (sb_q.size() == 0) report_fail("unexpected_done");
      else begin
        e = sb_q.pop_front();
        check("sb_data", ifc.o_data, e.data);
        check("sb_zero", ifc.o_zero, e.zero);
        check("sb_carry", ifc.o_carry, e.carry);
        check("sb_odd", ifc.o_odd, e.odd);
        check("sb_latency", en_edges, e.done_edge);
      end
    end
  end

  task automatic push_expect(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] t,
                             input logic latch, input int done_edge);
    logic [2*W-1:0] p;
    logic [W-1:0] r;
    logic c;
    exp_t e;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, t};
    case (op)
      2'd0: begin r = p[W-1:0];   c = (p[2*W-1:W] != 0); end
      2'd1: begin r = p[2*W-1:W]; c = (p[2*W-1:W] != 0); end
      2'd2: begin r = (t == 0) ? {W{1'b1}} : a / t; c = (t == 0); end
      default: begin r = (t == 0) ? a : a % t; c = (t == 0); end
    endcase
    m_data = r;
    if (latch) begin
      m_zero = (r == 0);
      m_carry = c;
      m_odd = r[0];
    end
    e.data = m_data; e.zero = m_zero; e.carry = m_carry; e.odd = m_odd;
    e.done_edge = done_edge;
    sb_q.push_back(e);
  endtask

  // call at a negedge with the unit in IDLE or DONE; returns at the negedge after acceptance
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] t,
                          input logic latch);
    sv_data = m_data; sv_zero = m_zero; sv_carry = m_carry; sv_odd = m_odd;
    ifc.clk_en = 1'b1;
    ifc.i_start = 1'b1;
    ifc.i_op = op;
    ifc.i_a = a;
    ifc.i_t = t;
    ifc.i_latch_flags = latch;
    push_expect(op, a, t, latch, en_edges + 1 + W);
    @(negedge clk);
    ifc.i_start = 1'b0;
    ifc.i_a = W'($urandom);
    ifc.i_t = W'($urandom);
    ifc.i_op = 2'($urandom);
    ifc.i_latch_flags = 1'($urandom);
    check("busy_after_accept", ifc.o_busy, 1'b1);
  endtask

  // mode: 0 clk_en high, 1 alternating, 2 random
  task automatic wait_done(input int mode, input bit inject_start);
    int n;
    n = 0;
    while (!(ifc.o_done && last_en)) begin
      if (n >= 100) begin
        report_fail("done_timeout");
        break;
      end
      case (mode)
        1: ifc.clk_en = n[0];
        2: ifc.clk_en = 1'($urandom_range(0, 1));
        default: ifc.clk_en = 1'b1;
      endcase
      if (inject_start && n == 2) begin
        ifc.i_start = 1'b1;
        ifc.i_op = 2'b00;
        ifc.i_a = 8'hFF;
        ifc.i_t = 8'hFF;
      end else ifc.i_start = 1'b0;
      @(negedge clk);
      n++;
    end
    ifc.clk_en = 1'b1;
    ifc.i_start = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] t,
                     input logic latch, input int mode);
    start_op(op, a, t, latch);
    wait_done(mode, 1'b0);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] d, input logic z,
                           input logic c, input logic o);
    check({name, "_data"}, ifc.o_data, d);
    check({name, "_zero"}, ifc.o_zero, z);
    check({name, "_carry"}, ifc.o_carry, c);
    check({name, "_odd"}, ifc.o_odd, o);
  endtask

  initial begin
    exp_t dummy;
    rst = 1'b1;
    ifc.clk_en = 1'b1;
    ifc.i_start = 1'b0;
    ifc.i_abort = 1'b0;
    ifc.i_op = 2'b00;
    ifc.i_latch_flags = 1'b0;
    ifc.i_a = '0;
    ifc.i_t = '0;
    m_data = '0; m_zero = 1'b0; m_carry = 1'b0; m_odd = 1'b0;
    #12;
    check("rst_busy", ifc.o_busy, 1'b0);
    check("rst_done", ifc.o_done, 1'b0);
    check_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(2'd0, 8'd13, 8'd11, 1'b1, 0);
    check_out("mul_13x11", 8'h8F, 1'b0, 1'b0, 1'b1);

    run(2'd0, 8'd200, 8'd200, 1'b1, 0);
    check_out("mul_200x200", 8'h40, 1'b0, 1'b1, 1'b0);
    run(2'd1, 8'd200, 8'd200, 1'b1, 0);   // back-to-back from DONE
    check_out("mulh_200x200", 8'h9C, 1'b0, 1'b1, 1'b0);

    run(2'd2, 8'd100, 8'd7, 1'b1, 0);
    check_out("div_100_7", 8'h0E, 1'b0, 1'b0, 1'b0);
    run(2'd3, 8'd100, 8'd7, 1'b1, 0);
    check_out("mod_100_7", 8'h02, 1'b0, 1'b0, 1'b0);
    run(2'd2, 8'd5, 8'd9, 1'b1, 0);
    check_out("div_5_9", 8'h00, 1'b1, 1'b0, 1'b0);

    run(2'd2, 8'h5A, 8'h00, 1'b1, 0);
    check_out("div_by_zero", 8'hFF, 1'b0, 1'b1, 1'b1);
    run(2'd3, 8'h5A, 8'h00, 1'b1, 0);
    check_out("mod_by_zero", 8'h5A, 1'b0, 1'b1, 1'b0);

    run(2'd0, 8'd13, 8'd11, 1'b1, 1);
    check_out("mul_clken_toggle", 8'h8F, 1'b0, 1'b0, 1'b1);

    start_op(2'd2, 8'd100, 8'd7, 1'b1);
    wait_done(0, 1'b1);
    check_out("start_in_run_ignored", 8'h0E, 1'b0, 1'b0, 1'b0);

    run(2'd0, 8'd200, 8'd200, 1'b0, 0);
    check_out("no_latch", 8'h40, 1'b0, 1'b0, 1'b0);

    // abort after four iterations: nothing architectural changes
    start_op(2'd0, 8'd13, 8'd11, 1'b1);
    repeat (4) @(negedge clk);
    ifc.i_abort = 1'b1;
    ifc.i_start = 1'b1;
    dummy = sb_q.pop_back();
    m_data = sv_data; m_zero = sv_zero; m_carry = sv_carry; m_odd = sv_odd;
    @(negedge clk);
    ifc.i_abort = 1'b0;
    ifc.i_start = 1'b0;
    check("abort_busy", ifc.o_busy, 1'b0);
    check("abort_done", ifc.o_done, 1'b0);
    repeat (12) @(negedge clk);
    check_out("abort_hold", 8'h40, 1'b0, 1'b0, 1'b0);

    // abort beats start while in DONE
    run(2'd2, 8'd100, 8'd7, 1'b1, 0);
    ifc.i_abort = 1'b1;
    ifc.i_start = 1'b1;
    @(negedge clk);
    ifc.i_abort = 1'b0;
    ifc.i_start = 1'b0;
    check("abort_in_done_busy", ifc.o_busy, 1'b0);
    check("abort_in_done_done", ifc.o_done, 1'b0);

    // reset in the middle of a run
    start_op(2'd0, 8'd13, 8'd11, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb_q.delete();
    m_data = '0; m_zero = 1'b0; m_carry = 1'b0; m_odd = 1'b0;
    check("midrst_busy", ifc.o_busy, 1'b0);
    check("midrst_done", ifc.o_done, 1'b0);
    check_out("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [W-1:0] a, t;
      op = 2'($urandom);
      a = W'($urandom);
      t = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) begin
          ifc.clk_en = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        ifc.clk_en = 1'b1;
      end
      start_op(op, a, t, 1'($urandom));
      wait_done(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
